cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Miss/refill controller sitting directly downstream of the direct-mapped data cache in the pipeline_exram datapath.
- Consumes the cache hit flag (`zero`) and read data.
- On a load miss, stalls the pipeline, fetches the word from external RAM over a req/ack handshake, and refills the cache.
- Stores are written through to external RAM, then allocated into the cache.

Parameters:
- WIDTH, 32, data word width (matches cache WIDTH).
- DEPTH, 3, cache index bits (matches cache DEPTH); not used internally except for documentation and assertions.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; counter is 8 bits wide.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- cpu_rd  in  1  load request, held by the pipeline until the stall drops.
- cpu_wr  in  1  store request, held by the pipeline until the stall drops.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  WIDTH  store data.
- cpu_rdata  out  WIDTH  load result.
- stall  out  1  pipeline freeze.
- cache_hit  in  1  cache `zero` output; 1 = tag match.
- cache_rdata  in  WIDTH  cache data output.
- cache_ena  out  1  cache RAM enable.
- cache_wena  out  1  cache write enable (also updates the tag).
- cache_addr  out  32  cache address.
- cache_wdata  out  WIDTH  cache fill data.
- mem_req  out  1  external RAM request.
- mem_we  out  1  external RAM write enable; 1 = write.
- mem_addr  out  32  word-aligned external address, bits [1:0] = 0.
- mem_wdata  out  WIDTH  external RAM write data.
- mem_ack  in  1  external RAM completion, one-cycle pulse.
- mem_rdata  in  WIDTH  external read data, valid in the mem_ack cycle.
- err  out  1  timeout pulse.

Behaviour:
- States: IDLE, RD_MEM, WR_MEM, FILL. State, addr_q, data_q and cnt are registered.
- Reset (async, immediate):
  - state = IDLE; addr_q, data_q and cnt = 0.
  - All outputs 0, including mem_req, stall and err.
  - Reset during RD_MEM/WR_MEM drops mem_req at once; the transaction is abandoned and no cache write occurs.
- IDLE:
  - cache_ena = cpu_rd | cpu_wr; cache_addr = cpu_addr.
  - Read hit (cpu_rd & cache_hit): cpu_rdata = cache_rdata combinationally, stall = 0, state stays IDLE.
  - Read miss (cpu_rd & ~cache_hit): stall = 1 combinationally in the same cycle. Latch addr_q = {cpu_addr[31:2], 2'b00}; next state RD_MEM.
  - cpu_wr: stall = 1. Latch addr_q and data_q = cpu_wdata; next state WR_MEM.
  - cpu_rd and cpu_wr both asserted: the write wins and the read is ignored.
- RD_MEM:
  - mem_req = 1, mem_we = 0, mem_addr = addr_q, stall = 1, cnt increments each cycle.
  - On mem_ack: data_q = mem_rdata; next state FILL.
- WR_MEM:
  - mem_req = 1, mem_we = 1, mem_addr = addr_q, mem_wdata = data_q, stall = 1, cnt increments.
  - On mem_ack: next state FILL (write-allocate).
- FILL (exactly one cycle):
  - cache_ena = cache_wena = 1, cache_addr = addr_q, cache_wdata = data_q.
  - cpu_rdata = data_q, stall = 0, cnt cleared; next state IDLE.
  - The cache latches the tag on the negedge of this cycle.
- Timeout: in RD_MEM/WR_MEM, when cnt reaches TIMEOUT with no ack:
  - err = 1 for one cycle, stall = 0, cpu_rdata = 0, no cache write, cnt cleared, next state IDLE.
- mem_ack outside RD_MEM/WR_MEM is ignored. mem_req stays high continuously from entry to ack; it never toggles mid-request.
- Latency:
  - Read hit: 0 extra cycles.
  - Miss detected at T0 with ack at Tk: stall is high T0..Tk, data is returned and stall released at Tk+1.
  - Store: same timing as a read miss.

Test Plan:
- Reset then idle: rst pulse mid-RD_MEM -> mem_req falls asynchronously, stall = 0, err = 0, cache_wena never asserted.
- Read hit: cache_hit = 1, cache_rdata = 0xDEADBEEF, cpu_rd at addr 0x10 -> cpu_rdata = 0xDEADBEEF in the same cycle, stall = 0, mem_req = 0.
- Read miss: cpu_rd at addr 0x0000_0106, hit = 0, ack after 3 cycles with 0x12345678:
  - mem_addr = 0x0000_0104.
  - stall high 4 cycles.
  - FILL cycle shows cache_wena = 1, cache_wdata = 0x12345678, cpu_rdata = 0x12345678.
- Store write-through: cpu_wr at 0x20, data 0xA5A5A5A5, ack after 1 cycle:
  - mem_we = 1, mem_wdata = 0xA5A5A5A5.
  - Then FILL with cache_wena = 1; a following read at 0x20 with cache_hit = 1 does not stall.
- Simultaneous cpu_rd & cpu_wr at 0x40 -> WR_MEM entered (mem_we = 1), no read request issued.
- Timeout: TIMEOUT = 4, read miss with no ack -> err pulses once at the 4th RD_MEM cycle, stall drops, cpu_rdata = 0, cache_wena stays 0, state returns to IDLE.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller behind the direct-mapped data cache: stalls on load misses and stores,
// runs a req/ack transfer to external RAM, then writes the word into the cache for one cycle.
module cache_refill_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall,
  input  logic             cache_hit,
  input  logic [WIDTH-1:0] cache_rdata,
  output logic             cache_ena,
  output logic             cache_wena,
  output logic [31:0]      cache_addr,
  output logic [WIDTH-1:0] cache_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, FILL} state_t;

  // The timeout fires in the TIMEOUT-th wait cycle, i.e. while cnt still holds TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [31:0]      addr_q, addr_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [7:0]       cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_nxt   = state;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    cnt_nxt     = cnt;
    cpu_rdata   = '0;
    stall       = 1'b0;
    cache_ena   = 1'b0;
    cache_wena  = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    err         = 1'b0;

    // Outputs are forced low for as long as reset is held, even with requests pending.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          cache_ena  = cpu_rd | cpu_wr;
          cache_addr = cpu_addr;
          cnt_nxt    = '0;
          if (cpu_wr) begin
            stall     = 1'b1;
            addr_nxt  = {cpu_addr[31:2], 2'b00};
            data_nxt  = cpu_wdata;
            state_nxt = WR_MEM;
          end else if (cpu_rd) begin
            if (cache_hit) begin
              cpu_rdata = cache_rdata;
            end else begin
              stall     = 1'b1;
              addr_nxt  = {cpu_addr[31:2], 2'b00};
              state_nxt = RD_MEM;
            end
          end
        end

        RD_MEM, WR_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (state == WR_MEM);
          mem_addr = addr_q;
          if (state == WR_MEM) mem_wdata = data_q;
          stall    = 1'b1;
          cnt_nxt  = cnt + 8'd1;
          if (mem_ack) begin
            if (state == RD_MEM) data_nxt = mem_rdata;
            state_nxt = FILL;
          end else if (cnt == CNT_LAST) begin
            // Abort: release the pipeline with a zero result and leave the cache untouched.
            err       = 1'b1;
            stall     = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end

        FILL: begin
          cache_ena   = 1'b1;
          cache_wena  = 1'b1;
          cache_addr  = addr_q;
          cache_wdata = data_q;
          cpu_rdata   = data_q;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // The pipeline must hold the request address while the transfer is outstanding.
  a_addr_held: assert property (@(posedge clk) disable iff (rst)
    (state == RD_MEM || state == WR_MEM) |-> cpu_addr[DEPTH+1:2] == addr_q[DEPTH+1:2]);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: stimulus pushes expected events into a queue and a
// negedge monitor pops and compares each request, fill, hit return and timeout the DUT shows.
module tb_cache_refill_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_rd, cpu_wr;
  logic [31:0]      cpu_addr;
  logic [WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic             stall;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_rdata;
  logic             cache_ena, cache_wena;
  logic [31:0]      cache_addr;
  logic [WIDTH-1:0] cache_wdata;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic             err;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.WIDTH(WIDTH), .DEPTH(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata), .cache_ena(cache_ena),
    .cache_wena(cache_wena), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  typedef enum logic [1:0] {EV_HIT, EV_REQ, EV_FILL, EV_ERR} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic prev_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
    ev_t e;
    e = '{kind: k, we: we, addr: a, data: d};
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      fail_now($sformatf("unexpected_%s: got event want none", k.name()));
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("ev_kind_%s", k.name()), 32'(k), 32'(e.kind));
    case (k)
      EV_REQ: begin
        check("req_we", 32'(mem_we), 32'(e.we));
        check("req_addr", mem_addr, e.addr);
        if (e.we) check("req_wdata", mem_wdata, e.data);
      end
      EV_FILL: begin
        check("fill_addr", cache_addr, e.addr);
        check("fill_wdata", cache_wdata, e.data);
        check("fill_rdata", cpu_rdata, e.data);
        check("fill_stall", 32'(stall), 32'd0);
      end
      EV_ERR: begin
        check("err_rdata", cpu_rdata, e.data);
        check("err_stall", 32'(stall), 32'd0);
      end
      default: begin
        check("hit_addr", cache_addr, e.addr);
        check("hit_rdata", cpu_rdata, e.data);
      end
    endcase
  endtask

  // Monitor: classify what the DUT presents each cycle and compare against the queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) observe(EV_REQ);
      if (cache_wena) observe(EV_FILL);
      if (err) observe(EV_ERR);
      if (cpu_rd && !stall && !cache_wena && !err) observe(EV_HIT);
      prev_req = mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd      = 1'b0;
    cpu_wr      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
  endtask

  // Request already driven in cycle T0; ack after ack_after wait cycles (0 = never).
  task automatic run_mem(input int ack_after, input logic [31:0] ack_data, input int exp_stall,
                         input string name);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(negedge clk);
    if (stall) stalls++;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(posedge clk);
      #1;
      mem_ack   = (n == ack_after);
      mem_rdata = (n == ack_after) ? ack_data : 32'h0;
      @(negedge clk);
      if (stall) begin
        stalls++;
        check({name, "_req_held"}, 32'(mem_req), 32'd1);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) fail_now({name, "_no_release: stall never dropped"});
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst       = 1'b1;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 32'h44;
    cpu_wdata = 32'h5555_AAAA;
    cache_hit = 1'b1;
    cache_rdata = 32'h7777_7777;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Held reset forces every output low regardless of requests.
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cache_ena", 32'(cache_ena), 32'd0);
    check("rst_cache_wena", 32'(cache_wena), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    step();
    idle_inputs();
    rst = 1'b0;

    // Read hit: data returned combinationally, no stall, no memory request.
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h10; cache_hit = 1'b1; cache_rdata = 32'hDEAD_BEEF;
    expect_ev(EV_HIT, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("hit_comb_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("hit_stall", 32'(stall), 32'd0);
    check("hit_mem_req", 32'(mem_req), 32'd0);
    check("hit_cache_ena", 32'(cache_ena), 32'd1);
    step();
    idle_inputs();

    // Read miss at an unaligned address, ack in the third wait cycle.
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0106; cache_hit = 1'b0;
    expect_ev(EV_REQ, 1'b0, 32'h0000_0104, 32'h0);
    expect_ev(EV_FILL, 1'b0, 32'h0000_0104, 32'h1234_5678);
    #1;
    check("miss_stall_same_cycle", 32'(stall), 32'd1);
    check("miss_no_req_t0", 32'(mem_req), 32'd0);
    run_mem(3, 32'h1234_5678, 4, "rd_miss");

    // Store write-through with a one-cycle ack; ack data must not leak into the fill.
    step();
    cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5_A5A5;
    expect_ev(EV_REQ, 1'b1, 32'h20, 32'hA5A5_A5A5);
    expect_ev(EV_FILL, 1'b1, 32'h20, 32'hA5A5_A5A5);
    run_mem(1, 32'hFFFF_0000, 2, "store");

    step();
    cpu_rd = 1'b1; cpu_addr = 32'h20; cache_hit = 1'b1; cache_rdata = 32'hA5A5_A5A5;
    expect_ev(EV_HIT, 1'b0, 32'h20, 32'hA5A5_A5A5);
    #1;
    check("store_then_hit_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();

    // Read and write together: the write wins even though the read would hit.
    step();
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0BAD_F00D;
    cache_hit = 1'b1; cache_rdata = 32'h1111_1111;
    expect_ev(EV_REQ, 1'b1, 32'h40, 32'h0BAD_F00D);
    expect_ev(EV_FILL, 1'b1, 32'h40, 32'h0BAD_F00D);
    #1;
    check("rdwr_stall", 32'(stall), 32'd1);
    run_mem(2, 32'h2222_2222, 3, "rdwr");

    // Timeout: no ack, err in the fourth wait cycle, no fill.
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0300; cache_hit = 1'b0;
    expect_ev(EV_REQ, 1'b0, 32'h0000_0300, 32'h0);
    expect_ev(EV_ERR, 1'b0, 32'h0, 32'h0);
    run_mem(0, 32'h0, 4, "timeout");
    check("timeout_err_once", 32'(err), 32'd0);
    check("timeout_idle_req", 32'(mem_req), 32'd0);

    // Stray ack while idle is ignored.
    step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0000;
    #1;
    check("stray_ack_req", 32'(mem_req), 32'd0);
    check("stray_ack_stall", 32'(stall), 32'd0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset in the middle of a read miss abandons the transfer.
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h80; cache_hit = 1'b0;
    expect_ev(EV_REQ, 1'b0, 32'h80, 32'h0);
    step();
    step();
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_fill", 32'(cache_wena), 32'd0);
    end

    step();
    cpu_rd = 1'b1; cpu_addr = 32'h10; cache_hit = 1'b1; cache_rdata = 32'h0F0F_0F0F;
    expect_ev(EV_HIT, 1'b0, 32'h10, 32'h0F0F_0F0F);
    step();
    idle_inputs();

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
